// File: rtl/cache_mem_burst_adapter.sv
// cache_mem_burst_adapter: splits cache line requests into word bus bursts.
// Optional stall timeout with sticky bus_err: CACHE_MEM_BURST_TIMEOUT_EN.
module cache_mem_burst_adapter #(
  parameter int ADDR_WIDTH       = 32,
  parameter int BLOCK_SIZE_BYTES = 32,
  parameter int BUS_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [BLOCK_SIZE_BYTES*8-1:0] mem_wdata,
  output logic [BLOCK_SIZE_BYTES*8-1:0] mem_rdata,
  output logic                          mem_wait,
  output logic                          bus_valid,
  input  logic                          bus_ready,
  output logic                          bus_we,
  output logic [ADDR_WIDTH-1:0]         bus_addr,
  output logic [BUS_WIDTH-1:0]          bus_wdata,
  input  logic                          bus_rvalid,
  input  logic [BUS_WIDTH-1:0]          bus_rdata,
  output logic                          bus_err
);

  localparam int LINE_W = BLOCK_SIZE_BYTES * 8;
  localparam int BEATS  = LINE_W / BUS_WIDTH;
  localparam int OFFSET = $clog2(BLOCK_SIZE_BYTES);
  localparam int CW     = $clog2(BEATS + 1);
  localparam int IW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [CW-1:0] FULL = CW'(BEATS);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BUS_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cmd_cnt;
  logic [CW-1:0]         r_rsp_cnt;
  logic [LINE_W-1:0]     r_wline;
  logic [LINE_W-1:0]     r_rdata;
  logic                  r_mem_wait;
  logic                  r_bus_valid;
  logic                  r_bus_we;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [BUS_WIDTH-1:0]  r_bus_wdata;

  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_acc;
  logic                  w_rsp;
  logic                  w_cmd_last;
  logic                  w_rsp_last;
  logic                  w_rsp_done;
  logic [IW-1:0]         w_rsp_idx;
  logic                  w_busy;
  logic                  w_unused;

  assign w_base = {mem_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
  assign w_acc  = r_bus_valid && bus_ready;
  assign w_busy = (r_state == S_WR) || (r_state == S_RD) ||
                  (r_state == S_DRAIN);

  // Responses only count while a read is collecting and the line is short.
  assign w_rsp = bus_rvalid && (r_rsp_cnt != FULL) &&
                 ((r_state == S_RD) || (r_state == S_DRAIN));

  assign w_cmd_last = (r_cmd_cnt == LAST);
  assign w_rsp_last = w_rsp && (r_rsp_cnt == LAST);
  assign w_rsp_done = w_rsp_last || (r_rsp_cnt == FULL);
  assign w_rsp_idx  = r_rsp_cnt[IW-1:0];

  assign mem_rdata = r_rdata;
  assign mem_wait  = r_mem_wait;
  assign bus_valid = r_bus_valid;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

`ifdef CACHE_MEM_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_stall;
  logic          r_err;

  assign bus_err  = r_err;
  assign w_unused = ^mem_addr[OFFSET-1:0];
`else
  assign bus_err  = 1'b0;
  assign w_unused = ^mem_addr[OFFSET-1:0] ^ (TIMEOUT_CYCLES == 0);
`endif

  // Burst FSM: command issue, response assembly and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_cnt   <= '0;
      r_rsp_cnt   <= '0;
      r_wline     <= '0;
      r_rdata     <= '0;
      r_mem_wait  <= 1'b1;
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
`ifdef CACHE_MEM_BURST_TIMEOUT_EN
      r_stall     <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cmd_cnt <= '0;
          r_rsp_cnt <= '0;
          if (mem_write) begin
            r_wline     <= mem_wdata;
            r_bus_valid <= 1'b1;
            r_bus_we    <= 1'b1;
            r_bus_addr  <= w_base;
            r_bus_wdata <= mem_wdata[BUS_WIDTH-1:0];
            r_state     <= S_WR;
          end else if (mem_read) begin
            r_bus_valid <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= w_base;
            r_bus_wdata <= '0;
            r_state     <= S_RD;
          end
        end
        S_WR: begin
          if (w_acc) begin
            r_cmd_cnt <= r_cmd_cnt + CW'(1);
            if (w_cmd_last) begin
              r_bus_valid <= 1'b0;
              r_mem_wait  <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_bus_addr  <= r_bus_addr + STEP;
              r_bus_wdata <= r_wline[2*BUS_WIDTH-1:BUS_WIDTH];
              r_wline     <= r_wline >> BUS_WIDTH;
            end
          end
        end
        S_RD: begin
          if (w_rsp) begin
            r_rdata[w_rsp_idx*BUS_WIDTH +: BUS_WIDTH] <= bus_rdata;
            r_rsp_cnt <= r_rsp_cnt + CW'(1);
          end
          if (w_acc) begin
            r_cmd_cnt <= r_cmd_cnt + CW'(1);
            if (w_cmd_last) begin
              r_bus_valid <= 1'b0;
              if (w_rsp_done) begin
                r_mem_wait <= 1'b0;
                r_state    <= S_DONE;
              end else begin
                r_state <= S_DRAIN;
              end
            end else begin
              r_bus_addr <= r_bus_addr + STEP;
            end
          end
        end
        S_DRAIN: begin
          if (w_rsp) begin
            r_rdata[w_rsp_idx*BUS_WIDTH +: BUS_WIDTH] <= bus_rdata;
            r_rsp_cnt <= r_rsp_cnt + CW'(1);
            if (w_rsp_last) begin
              r_mem_wait <= 1'b0;
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_mem_wait <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
`ifdef CACHE_MEM_BURST_TIMEOUT_EN
      if (w_busy) begin
        if (w_acc || bus_rvalid) begin
          r_stall <= '0;
        end else if (r_stall == TO_LAST) begin
          r_stall     <= '0;
          r_state     <= S_DONE;
          r_mem_wait  <= 1'b0;
          r_bus_valid <= 1'b0;
          r_err       <= 1'b1;
          if (r_state != S_WR) begin
            for (int k = 0; k < BEATS; k++) begin
              if (CW'(k) >= r_rsp_cnt) begin
                r_rdata[k*BUS_WIDTH +: BUS_WIDTH] <= '0;
              end
            end
          end
        end else begin
          r_stall <= r_stall + TW'(1);
        end
      end else begin
        r_stall <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cache_mem_burst_adapter.sv
// tb_cache_mem_burst_adapter: scoreboard bench with a memory model and
// a randomised bus agent (ready throttling, delayed in-order responses).
module tb_cache_mem_burst_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_wait;
  logic         bus_valid;
  logic         bus_ready;
  logic         bus_we;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_rvalid;
  logic [31:0]  bus_rdata;
  logic         bus_err;

  cache_mem_burst_adapter #(
    .ADDR_WIDTH      (32),
    .BLOCK_SIZE_BYTES(32),
    .BUS_WIDTH       (32),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_wait  (mem_wait),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    bit           rd;
    logic [255:0] line;
    bit           err;
  } done_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  cmd_t  exp_cmd_q[$];
  done_t exp_done_q[$];
  rsp_t  rsp_q[$];
  logic [31:0] mem_model [logic [31:0]];

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int acc = 0;
  int done_cnt = 0;
  int ready_pct = 100;
  int max_dly = 0;
  int last_due = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bus agent: drives ready/responses, checks each accepted beat.
  bit          stalled = 0;
  bit          p_we;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  always begin
    cmd_t c;
    rsp_t r;
    @(negedge clk);
    cyc++;
    bus_ready = ($urandom_range(99) < ready_pct);
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      bus_rvalid = 1'b1;
      bus_rdata  = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else begin
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
    end
    #1;
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled && mem_wait) begin
        chk("hold_valid", 256'(bus_valid), 256'(1));
        chk("hold_cmd", 256'({bus_we, bus_addr, bus_wdata}),
            256'({p_we, p_addr, p_wdata}));
      end
      stalled = bus_valid && !bus_ready;
      p_we    = bus_we;
      p_addr  = bus_addr;
      p_wdata = bus_wdata;
      if (bus_valid && bus_ready) begin
        acc++;
        if (exp_cmd_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL extra_beat: got addr %0h expected none", bus_addr);
        end else begin
          c = exp_cmd_q.pop_front();
          chk("beat_we", 256'(bus_we), 256'(c.we));
          chk("beat_addr", 256'(bus_addr), 256'(c.addr));
          if (c.we) chk("beat_wdata", 256'(bus_wdata), 256'(c.data));
        end
        if (!bus_we) begin
          r.data = mem_model.exists(bus_addr) ? mem_model[bus_addr]
                                              : 32'hBAD0_0000;
          r.due  = cyc + 1 + int'($urandom_range(max_dly));
          if (r.due <= last_due) r.due = last_due + 1;
          last_due = r.due;
          rsp_q.push_back(r);
        end
      end
    end
  end

  // Done monitor: pops the expected line result on each mem_wait=0.
  bit prev_wait = 1;
  always begin
    done_t d;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      prev_wait = 1;
    end else begin
      if (!mem_wait) begin
        done_cnt++;
        chk("pulse_width", 256'(prev_wait), 256'(1));
        chk("beats_left", 256'(exp_cmd_q.size()), 256'(0));
        if (exp_done_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL extra_done: got done expected none");
        end else begin
          d = exp_done_q.pop_front();
          chk("bus_err", 256'(bus_err), 256'(d.err));
          if (d.rd) chk("rdata", mem_rdata, d.line);
        end
      end
      prev_wait = mem_wait;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic expect_txn(input bit wr, input logic [31:0] addr,
                            input logic [255:0] ln, input bit tmo);
    logic [31:0]  base;
    logic [31:0]  a;
    logic [255:0] eline;
    cmd_t c;
    done_t d;
    base  = {addr[31:5], 5'b0};
    eline = '0;
    for (int k = 0; k < 8; k++) begin
      a = base + 32'(4 * k);
      if (wr) mem_model[a] = ln[k*32 +: 32];
      else if (!mem_model.exists(a)) mem_model[a] = $urandom;
      eline[k*32 +: 32] = mem_model[a];
      if (!tmo) begin
        c.we   = wr;
        c.addr = a;
        c.data = ln[k*32 +: 32];
        exp_cmd_q.push_back(c);
      end
    end
    d.rd   = !wr;
    d.line = tmo ? '0 : eline;
    d.err  = tmo;
    exp_done_q.push_back(d);
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr,
                       input logic [255:0] ln, input int exp_lat,
                       input bit both, input bit tmo);
    int n;
    int dc;
    expect_txn(wr, addr, ln, tmo);
    dc        = done_cnt;
    mem_addr  = addr;
    mem_wdata = wr ? ln : {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
    mem_write = wr;
    mem_read  = !wr || both;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (mem_wait && n < 500);
    chk("done_seen", 256'(mem_wait), 256'(0));
    if (exp_lat >= 0) chk("latency", 256'(n), 256'(exp_lat));
    chk("done_count", 256'(done_cnt), 256'(dc + 1));
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_wait"}, 256'(mem_wait), 256'(1));
    chk({nm, "_valid"}, 256'(bus_valid), 256'(0));
    chk({nm, "_we"}, 256'(bus_we), 256'(0));
    chk({nm, "_addr"}, 256'(bus_addr), 256'(0));
    chk({nm, "_wdata"}, 256'(bus_wdata), 256'(0));
    chk({nm, "_rdata"}, mem_rdata, 256'(0));
    chk({nm, "_err"}, 256'(bus_err), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] ln;
    logic [255:0] t2line;
    logic [31:0]  addr;
    bit           wr;
    int           a0;
    int           n;
    rst_n      = 1'b0;
    mem_addr   = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    #12;
    check_reset("rst");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);
    check_reset("post_rst");

    // T1: single write burst, full-rate bus
    for (int k = 0; k < 8; k++) ln[k*32 +: 32] = 32'hA0 + 32'(k);
    issue(1, 32'h0000_1234, ln, 9, 0, 0);
    idle(2);

    // T2: single read burst, responses one cycle after accept
    t2line = '0;
    for (int k = 0; k < 8; k++) begin
      mem_model[32'h4000 + 32'(4 * k)] = 32'h11 * 32'(k);
      t2line[k*32 +: 32] = 32'h11 * 32'(k);
    end
    issue(0, 32'h0000_4000, '0, 10, 0, 0);
    idle(3);
    chk("t2_rdata_stable", mem_rdata, t2line);

    // T3: random traffic with backpressure and late responses
    ready_pct = 50;
    max_dly   = 5;
    for (int i = 0; i < 16; i++) begin
      wr   = 1'($urandom_range(1));
      addr = $urandom & 32'h0000_07FF;
      for (int k = 0; k < 8; k++) ln[k*32 +: 32] = $urandom;
      issue(wr, addr, ln, -1, (i % 4) == 1, 0);
      if ($urandom_range(1) == 1) idle(int'($urandom_range(3, 1)));
    end
    idle(8);

    // T4: writeback followed immediately by fill
    ready_pct = 100;
    max_dly   = 0;
    for (int k = 0; k < 8; k++) ln[k*32 +: 32] = $urandom;
    issue(1, 32'h0000_2040, ln, 9, 0, 0);
    issue(0, 32'h0000_2040, '0, 11, 0, 0);
    idle(3);

    // T5: reset in the middle of a read
    expect_txn(0, 32'h0000_8000, '0, 0);
    mem_addr = 32'h0000_8000;
    mem_read = 1'b1;
    a0 = acc;
    n  = 0;
    while (acc < a0 + 3 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    @(posedge clk);
    #2;
    chk("t5_beats", 256'(acc - a0), 256'(3));
    rst_n    = 1'b0;
    mem_read = 1'b0;
    #1;
    check_reset("t5_async");
    exp_cmd_q.delete();
    exp_done_q.delete();
    rsp_q.delete();
    last_due = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    rsp_q.push_back('{32'hDEAD_BEEF, cyc + 1});
    idle(4);
    check_reset("t5_stray");
    issue(0, 32'h0000_8000, '0, 10, 0, 0);
    idle(2);

`ifdef CACHE_MEM_BURST_TIMEOUT_EN
    // T6: bus never accepts, the stall limit aborts the read
    ready_pct = 0;
    issue(0, 32'h0000_C000, '0, 17, 0, 1);
    chk("t6_err", 256'(bus_err), 256'(1));
    chk("t6_rdata", mem_rdata, 256'(0));
    ready_pct = 100;
    idle(3);
    chk("t6_err_sticky", 256'(bus_err), 256'(1));
    chk("t6_valid", 256'(bus_valid), 256'(0));
`else
    chk("err_tied", 256'(bus_err), 256'(0));
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
